// File: rtl/host_notify_display_mode_dispatch.sv
// Initiator for the host display-mode notification: unpacks a bridge parameter word,
// pulses the request, waits for done under a timeout and hands back the grayscale affirmation.
package pocket;
  typedef enum logic [7:0] {
    DM_COLOR  = 8'd0,
    DM_MONO   = 8'd1,
    DM_GRAY4  = 8'd2,
    DM_GRAY16 = 8'd3
  } display_mode_e;

  typedef enum logic [1:0] {
    grayscale_unknown       = 2'd0,
    grayscale_not_supported = 2'd1,
    grayscale_supported     = 2'd2
  } affirm_e;

  typedef struct packed {
    logic          grayscale;
    display_mode_e display_mode;
  } host_notify_display_mode_param_t;

  typedef struct packed {
    affirm_e affirm_grayscale;
  } host_notify_display_mode_response_t;
endpackage

interface host_notify_display_mode_if;
  import pocket::*;
  logic                               valid;
  host_notify_display_mode_param_t    param;
  logic                               done;
  host_notify_display_mode_response_t response;

  modport initiator (output valid, output param, input done, input response);
  modport responder (input valid, input param, output done, output response);
endinterface

// Handshakes: cmd_* and rsp_* transfer on the cycle where valid && ready are both high;
// the source holds valid and payload stable until then.
module host_notify_display_mode_dispatch
  import pocket::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [31:0]                cmd_param,
  host_notify_display_mode_if.initiator host_notify_display_mode,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_word,
  output logic [1:0]                 rsp_status,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam int MW = $bits(display_mode_e);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q;
  host_notify_display_mode_param_t param_q;
  logic [31:0]                     rsp_word_q;
  logic [1:0]                      rsp_status_q;
  logic                            accept;

  // Only the mode field and the grayscale flag carry meaning.
  logic unused_param_bits;
  assign unused_param_bits = ^cmd_param[30:MW];

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (host_notify_display_mode.done || cnt_q == CNT_LAST) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      param_q      <= '0;
      rsp_word_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        param_q.grayscale    <= cmd_param[31];
        param_q.display_mode <= display_mode_e'(cmd_param[MW-1:0]);
        cnt_q                <= '0;
      end
      if (state_q == S_WAIT) begin
        // done takes priority over a coincident timeout.
        if (host_notify_display_mode.done) begin
          rsp_word_q   <= 32'(host_notify_display_mode.response.affirm_grayscale);
          rsp_status_q <= ST_OK;
        end else if (cnt_q == CNT_LAST) begin
          rsp_word_q   <= '0;
          rsp_status_q <= ST_TIMEOUT;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign host_notify_display_mode.valid = (state_q == S_ISSUE);
  assign host_notify_display_mode.param = param_q;
  assign cmd_ready  = (state_q == S_IDLE) && !reset;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_word   = rsp_word_q;
  assign rsp_status = rsp_status_q;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule
